pipeline_hazard_sram_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Drives Freeze and Flush of the IF_ID and ID_EXE registers, and Freeze of the EXE_MEM and MEM_WB registers.
- Combines three sources: load-use and no-forwarding data hazards; branch-taken flushes; a multi-cycle SRAM access FSM that holds the whole pipeline while external SRAM completes.

---
 rtl/pipeline_hazard_sram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipeline_hazard_sram_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_sram_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_sram_ctrl
//
// Purpose:
//   Central stall/flush sequencer for the 5-stage ARM pipeline. It combines
//   three sources of pipeline control:
//     - load-use hazards (forwarding on) or RAW hazards (forwarding off),
//     - branch-taken flushes,
//     - a multi-cycle SRAM access FSM that freezes the whole pipeline while
//       the external SRAM completes.
//
// Handshake: there is no valid/ready channel here. A memory request is any
// cycle in which EXE_MEM holds a load or a store (mem_r_en | mem_w_en). The
// request is accepted in the same cycle it is seen and the pipeline is held
// (freeze_back) until the access finishes. The DONE cycle releases the
// freeze so the memory instruction can advance.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   forward_en      1 = forwarding unit active, 0 = stall on every RAW hazard
//   id_src1/_valid  first source register of the ID instruction
//   id_src2/_valid  second source register (Rm, or Rd of a store)
//   exe_dest, exe_wb_en, exe_mem_r_en   fields held in ID_EXE
//   mem_dest, mem_wb_en, mem_r_en, mem_w_en   fields held in EXE_MEM
//   branch_taken    branch resolved taken (from ID_EXE)
//   freeze_front    PC and IF_ID freeze
//   freeze_back     ID_EXE, EXE_MEM, MEM_WB freeze
//   flush_if_id     IF_ID flush
//   flush_id_exe    ID_EXE flush (bubble insert)
//   sram_we_n       SRAM write strobe, active low
//   rdata_latch     single-cycle pulse: capture SRAM read data in MEM stage
//   stall_cnt       saturating count of cycles with freeze_front = 1
//   dbg_state       current SRAM FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// -----------------------------------------------------------------------------
module pipeline_hazard_sram_ctrl #(
    parameter int SRAM_WAIT = 4,
    parameter int CNT_W     = 4,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic [3:0]        id_src1,
    input  logic              id_src1_valid,
    input  logic [3:0]        id_src2,
    input  logic              id_src2_valid,
    input  logic [3:0]        exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [3:0]        mem_dest,
    input  logic              mem_wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              branch_taken,
    output logic              freeze_front,
    output logic              freeze_back,
    output logic              flush_if_id,
    output logic              flush_id_exe,
    output logic              sram_we_n,
    output logic              rdata_latch,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [STAT_W-1:0]   stall_cnt_q;
    logic [STAT_W-1:0]   stall_cnt_d;

    logic req;
    logic sram_freeze;
    logic last_wait;
    logic exe_match;
    logic mem_match;
    logic hazard;
    logic hazard_eff;

    assign req       = mem_r_en | mem_w_en;
    assign last_wait = (state_q == ACCESS) && (cnt_q == CNT_LAST);

    // The combinational outputs are gated with rst so that holding reset
    // drops every freeze/flush immediately, even with a request present.
    assign sram_freeze = rst & (((state_q == IDLE) & req) | (state_q == ACCESS));

    // ID instruction reads the register written by the stage in question.
    assign exe_match = (id_src1_valid & (id_src1 == exe_dest)) |
                       (id_src2_valid & (id_src2 == exe_dest));
    assign mem_match = (id_src1_valid & (id_src1 == mem_dest)) |
                       (id_src2_valid & (id_src2 == mem_dest));

    always_comb begin
        hazard = 1'b0;
        if (forward_en) begin
            // Only a load in EXE cannot be forwarded in time.
            hazard = exe_mem_r_en & exe_match;
        end else begin
            hazard = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
        end
    end

    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign hazard_eff = rst & hazard & ~branch_taken;

    assign freeze_back  = sram_freeze;
    assign freeze_front = sram_freeze | hazard_eff;
    // Flush overrides Freeze in the pipeline registers, so it must stay low
    // while the SRAM holds the pipeline or the held instruction is lost.
    assign flush_if_id  = rst & branch_taken & ~sram_freeze;
    assign flush_id_exe = rst & (branch_taken | hazard_eff) & ~sram_freeze;
    assign sram_we_n    = ~(mem_w_en & sram_freeze);
    assign rdata_latch  = rst & mem_r_en & last_wait;

    assign stall_cnt = stall_cnt_q;
    assign dbg_state = state_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze_front && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    // SRAM access FSM. A request still present in DONE belongs to the
    // instruction that just finished, so DONE always returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= ACCESS;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sram_ctrl.sv
module tb_pipeline_hazard_sram_ctrl;

  localparam int SRAM_WAIT = 4;
  localparam int CNT_W     = 4;
  localparam int STAT_W    = 6;   // small so saturation is reachable

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              forward_en;
  logic [3:0]        id_src1, id_src2, exe_dest, mem_dest;
  logic              id_src1_valid, id_src2_valid;
  logic              exe_wb_en, exe_mem_r_en, mem_wb_en, mem_r_en, mem_w_en;
  logic              branch_taken;
  logic              freeze_front, freeze_back, flush_if_id, flush_id_exe;
  logic              sram_we_n, rdata_latch;
  logic [STAT_W-1:0] stall_cnt;
  logic [1:0]        dbg_state;

  pipeline_hazard_sram_ctrl #(
    .SRAM_WAIT(SRAM_WAIT), .CNT_W(CNT_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src1_valid(id_src1_valid),
    .id_src2(id_src2), .id_src2_valid(id_src2_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .branch_taken(branch_taken),
    .freeze_front(freeze_front), .freeze_back(freeze_back),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .sram_we_n(sram_we_n), .rdata_latch(rdata_latch),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An access is modelled as "cycles of freeze still owed" plus a one-cycle
  // cool-down after it ends, during which a lingering request is ignored.
  int busy_left   = 0;
  bit cool_down   = 0;
  int stall_model = 0;
  bit m_front;

  function automatic bit reads_reg(input logic [3:0] r);
    return (id_src1_valid && id_src1 == r) || (id_src2_valid && id_src2 == r);
  endfunction

  task automatic model_reset();
    busy_left   = 0;
    cool_down   = 0;
    stall_model = 0;
  endtask

  // Compare every output for the current inputs, then advance one clock.
  task automatic step();
    bit req, frz, haz, haz_eff, rd;
    #3;
    req = mem_r_en || mem_w_en;
    if (!rst) begin
      frz = 0; haz_eff = 0; rd = 0;
    end else begin
      frz = cool_down ? 1'b0 : (busy_left > 0 ? 1'b1 : req);
      if (forward_en) haz = exe_mem_r_en && reads_reg(exe_dest);
      else haz = (exe_wb_en && reads_reg(exe_dest)) || (mem_wb_en && reads_reg(mem_dest));
      haz_eff = haz && !branch_taken;
      rd = !cool_down && busy_left == 1 && mem_r_en;
    end
    m_front = frz || haz_eff;
    check("freeze_back",  freeze_back,  frz);
    check("freeze_front", freeze_front, m_front);
    check("flush_if_id",  flush_if_id,  rst && branch_taken && !frz);
    check("flush_id_exe", flush_id_exe, rst && (branch_taken || haz_eff) && !frz);
    check("sram_we_n",    sram_we_n,    !(mem_w_en && frz));
    check("rdata_latch",  rdata_latch,  rd);
    check("stall_cnt",    stall_cnt,    stall_model);
    @(posedge clk);
    if (rst) begin
      if (m_front && stall_model < (1 << STAT_W) - 1) stall_model++;
      if (cool_down) cool_down = 0;
      else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) cool_down = 1;
      end else if (req) busy_left = SRAM_WAIT - 1;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    forward_en = 1; id_src1 = 0; id_src1_valid = 0; id_src2 = 0; id_src2_valid = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
    mem_r_en = 0; mem_w_en = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic drive_random();
    int r;
    forward_en    = 1'($urandom_range(0, 1));
    id_src1       = 4'($urandom_range(0, 3));
    id_src2       = 4'($urandom_range(0, 3));
    id_src1_valid = 1'($urandom_range(0, 1));
    id_src2_valid = 1'($urandom_range(0, 1));
    exe_dest      = 4'($urandom_range(0, 3));
    mem_dest      = 4'($urandom_range(0, 3));
    exe_wb_en     = 1'($urandom_range(0, 1));
    exe_mem_r_en  = 1'($urandom_range(0, 1));
    mem_wb_en     = 1'($urandom_range(0, 1));
    branch_taken  = ($urandom_range(0, 4) == 0);
    r = $urandom_range(0, 9);
    mem_r_en = (r < 2);
    mem_w_en = (r == 2);
  endtask

  // ---------------- stimulus ----------------
  int stall_start;

  initial begin
    drive_idle();
    rst = 0;
    mem_r_en = 1;
    @(posedge clk); #1;

    // Reset held with a pending request: everything quiet.
    step();
    check("rst_state", dbg_state, 0);
    rst = 1;
    // First freeze appears in the cycle the request is sampled.
    step();
    mem_r_en = 0;
    repeat (6) step();

    // Single load: 4 freeze cycles, latch in cycle 3, 4 stalls counted.
    do_reset();
    mem_r_en = 1;
    repeat (5) step();
    check("load_stall_total", stall_cnt, 4);
    mem_r_en = 0;
    step();

    // Store then load back to back: 10 cycles, second freeze in cycle 5.
    mem_w_en = 1;
    repeat (5) step();
    mem_w_en = 0; mem_r_en = 1;
    repeat (5) step();
    mem_r_en = 0;
    check("st_ld_stalls", stall_cnt, 12);
    step();

    // Load-use with forwarding: one-cycle stall, bubble inserted.
    exe_mem_r_en = 1; exe_dest = 3; id_src1 = 3; id_src1_valid = 1;
    step();
    drive_idle();
    step();

    // No forwarding: RAW against MEM stage, then same with src2 unread.
    forward_en = 0; mem_wb_en = 1; mem_dest = 5; id_src2 = 5; id_src2_valid = 1;
    step();
    id_src2_valid = 0;
    step();
    drive_idle();

    // Branch during SRAM access plus simultaneous hazard.
    mem_r_en = 1;
    step();
    branch_taken = 1; exe_mem_r_en = 1; exe_dest = 2; id_src1 = 2; id_src1_valid = 1;
    repeat (4) step();
    drive_idle();
    step();

    // Reset mid-access drops freezes at once.
    mem_w_en = 1;
    repeat (2) step();
    #2;
    rst = 0;
    #1;
    check("arst_freeze_back", freeze_back, 0);
    check("arst_freeze_front", freeze_front, 0);
    check("arst_we_n", sram_we_n, 1);
    check("arst_stall_cnt", stall_cnt, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    drive_idle();
    step();

    // Random traffic, long enough to saturate the stall counter.
    stall_start = 0;
    for (int i = 0; i < 800; i++) begin
      drive_random();
      step();
    end
    drive_idle();
    repeat (SRAM_WAIT + 2) step();
    check("stall_saturated", stall_cnt, (1 << STAT_W) - 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
